wb_ppm_rx: RTL and testbench



---
 rtl/ppm_rx_pkg.sv | 22 ++
 rtl/ppm_rx_decoder.sv | 126 ++++++++++++
 rtl/wb_ppm_rx.sv | 156 +++++++++++++++
 tb/tb_wb_ppm_rx.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ppm_rx_pkg.sv
// Shared constants, register offsets and decoder state encoding for the PPM receiver.
package ppm_rx_pkg;

  // Interval classification thresholds, in microseconds.
  localparam int SYNC_MIN_US  = 3000;
  localparam int PULSE_MIN_US = 700;
  localparam int PULSE_MAX_US = 2300;
  localparam int TIMEOUT_US   = 25000;
  localparam int MIN_CHANNELS = 4;

  // Register word indices, i.e. wb_adr_i[5:2].
  localparam logic [3:0] REG_STATUS   = 4'h0;
  localparam logic [3:0] REG_CTRL     = 4'h1;
  localparam logic [3:0] REG_FAILSAFE = 4'h2;
  localparam logic [3:0] REG_CH_BASE  = 4'h8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } ppm_state_e;

endpackage

// File: rtl/ppm_rx_decoder.sv
// PPM stream decoder: input synchronizer, 1 us prescaler, interval counter,
// IDLE/FRAME state machine and per-channel shadow registers. Emits one-cycle
// commit, error and signal-loss strobes; the current state is exposed on `state`.
module ppm_rx_decoder
  import ppm_rx_pkg::*;
#(
  parameter int clk_freq     = 50000000,
  parameter int max_channels = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic                           ppm_in,
  output logic                           commit,
  output logic                           err,
  output logic                           lost,
  output logic [max_channels-1:0][15:0]  shadow,
  output logic [3:0]                     num_ch,
  output ppm_state_e                     state
);

  localparam int DIV = clk_freq / 1000000;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic           sync1, sync2, sync3;
  logic           rise;
  logic [PW-1:0]  pre_cnt;
  logic           tick;
  logic [15:0]    us_cnt;
  logic [3:0]     ch_idx;
  logic           is_sync, is_pulse, store;
  ppm_state_e     next_state;

  // Two-flop synchronizer plus edge register for the asynchronous PPM input.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= ppm_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise = sync2 & ~sync3;
  assign tick = (pre_cnt == PW'(DIV - 1));

  // Free-running prescaler producing one tick per microsecond.
  always_ff @(posedge clk) begin
    if (rst || tick) pre_cnt <= '0;
    else             pre_cnt <= pre_cnt + PW'(1);
  end

  // Microsecond interval counter. On an edge the old value has already been
  // classified this cycle; a tick landing on the edge cycle belongs to the new
  // interval, so the counter restarts at 1 rather than 0.
  always_ff @(posedge clk) begin
    if (rst || !enable)                    us_cnt <= '0;
    else if (rise)                         us_cnt <= tick ? 16'd1 : 16'd0;
    else if (tick && us_cnt != 16'hFFFF)   us_cnt <= us_cnt + 16'd1;
  end

  assign is_sync  = (us_cnt >= 16'(SYNC_MIN_US));
  assign is_pulse = (us_cnt >= 16'(PULSE_MIN_US)) && (us_cnt <= 16'(PULSE_MAX_US));
  // Fires once per silent gap, on the tick that carries the counter to the timeout.
  assign lost     = enable & tick & ~rise & (us_cnt == 16'(TIMEOUT_US - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next-state logic: a sync opens a frame, a bad interval or silence drops back.
  always_comb begin
    next_state = state;
    if (!enable || lost) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (rise && is_sync) next_state = ST_FRAME;
        ST_FRAME: if (rise && !is_sync && !is_pulse) next_state = ST_IDLE;
        default:  next_state = ST_IDLE;
      endcase
    end
  end

  // Output logic: decide store / commit / error for the edge seen in FRAME.
  always_comb begin
    commit = 1'b0;
    err    = 1'b0;
    store  = 1'b0;
    if (enable && state == ST_FRAME && rise) begin
      if (is_sync) begin
        if (ch_idx >= 4'(MIN_CHANNELS)) commit = 1'b1;
        else                            err    = 1'b1;
      end else if (is_pulse) begin
        store = (ch_idx < 4'(max_channels));
      end else begin
        err = 1'b1;
      end
    end
  end

  // Channel index: advances per stored pulse, restarts at every frame boundary.
  always_ff @(posedge clk) begin
    if (rst || !enable || lost || commit || err) ch_idx <= '0;
    else if (store)                              ch_idx <= ch_idx + 4'd1;
  end

  // Shadow registers collect the frame in progress until the closing sync.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
    end else begin
      for (int n = 0; n < max_channels; n++) begin
        if (store && ch_idx == 4'(n)) shadow[n] <= us_cnt;
      end
    end
  end

  assign num_ch = ch_idx;

endmodule

// File: rtl/wb_ppm_rx.sv
// Wishbone slave front end for the PPM receiver: bus decode plus the STATUS,
// CTRL, FAILSAFE and CHn registers. Define PPM_RX_FAILSAFE_EN to implement the
// FAILSAFE register and load it into every channel on signal loss.
module wb_ppm_rx
  import ppm_rx_pkg::*;
#(
  parameter int clk_freq     = 50000000,
  parameter int max_channels = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  output logic        wb_ack_o,
  input  logic        ppm_in,
  output logic        intr
);

  // Handshake: an access is taken when stb & cyc are high and no ack is
  // currently out; ack follows one cycle later for exactly one cycle, writes
  // land and read data is registered on that same edge.
  logic        access, wr;
  logic [3:0]  reg_idx;
  logic [31:0] rdata;

  logic        dec_commit, dec_err, dec_lost;
  logic [max_channels-1:0][15:0] dec_shadow;
  logic [3:0]  dec_num_ch;
  ppm_state_e  dec_state;

  logic        enable, irq_en;
  logic        valid, frame_done, error;
  logic [3:0]  num_ch;
  logic [15:0] frame_cnt;
  logic [max_channels-1:0][15:0] ch;
`ifdef PPM_RX_FAILSAFE_EN
  localparam logic [15:0] FAILSAFE_RESET = 16'd1000;
  logic [15:0] failsafe;
`endif

  assign access  = wb_stb_i & wb_cyc_i & ~wb_ack_o;
  assign wr      = access & wb_we_i;
  assign reg_idx = wb_adr_i[5:2];
  assign intr    = irq_en & frame_done;

  logic unused_bits;
  assign unused_bits = ^{wb_sel_i, wb_adr_i[31:6], wb_adr_i[1:0], wb_dat_i, dec_state};

  ppm_rx_decoder #(
    .clk_freq     (clk_freq),
    .max_channels (max_channels)
  ) u_dec (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .ppm_in (ppm_in),
    .commit (dec_commit),
    .err    (dec_err),
    .lost   (dec_lost),
    .shadow (dec_shadow),
    .num_ch (dec_num_ch),
    .state  (dec_state)
  );

  // Bus acknowledge and registered read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= access;
      if (access && !wb_we_i) wb_dat_o <= rdata;
    end
  end

  // CTRL and (optional) FAILSAFE registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      enable <= 1'b0;
      irq_en <= 1'b0;
`ifdef PPM_RX_FAILSAFE_EN
      failsafe <= FAILSAFE_RESET;
`endif
    end else if (wr) begin
      if (reg_idx == REG_CTRL) begin
        enable <= wb_dat_i[0];
        irq_en <= wb_dat_i[1];
      end
`ifdef PPM_RX_FAILSAFE_EN
      if (reg_idx == REG_FAILSAFE) failsafe <= wb_dat_i[15:0];
`endif
    end
  end

  // STATUS: hardware sets take priority over a simultaneous write-one-to-clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid      <= 1'b0;
      frame_done <= 1'b0;
      error      <= 1'b0;
      num_ch     <= '0;
      frame_cnt  <= '0;
    end else begin
      if (dec_commit) begin
        valid     <= 1'b1;
        num_ch    <= dec_num_ch;
        frame_cnt <= frame_cnt + 16'd1;
      end else if (dec_lost) begin
        valid <= 1'b0;
      end
      if (dec_commit)                                   frame_done <= 1'b1;
      else if (wr && reg_idx == REG_STATUS && wb_dat_i[1]) frame_done <= 1'b0;
      if (dec_err)                                      error <= 1'b1;
      else if (wr && reg_idx == REG_STATUS && wb_dat_i[2]) error <= 1'b0;
    end
  end

  // Channel registers: whole frame committed at once, failsafe on loss if built in.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch <= '0;
    end else if (dec_commit) begin
      ch <= dec_shadow;
`ifdef PPM_RX_FAILSAFE_EN
    end else if (dec_lost) begin
      for (int n = 0; n < max_channels; n++) ch[n] <= failsafe;
`endif
    end
  end

  // Read multiplexer; unmapped offsets and absent channels read as zero.
  always_comb begin
    rdata = '0;
    case (reg_idx)
      REG_STATUS:   rdata = {frame_cnt, 4'h0, num_ch, 5'h0, error, frame_done, valid};
      REG_CTRL:     rdata = {30'h0, irq_en, enable};
`ifdef PPM_RX_FAILSAFE_EN
      REG_FAILSAFE: rdata = {16'h0, failsafe};
`else
      REG_FAILSAFE: rdata = '0;
`endif
      default:      rdata = '0;
    endcase
    if (reg_idx >= REG_CH_BASE) begin
      for (int n = 0; n < max_channels; n++) begin
        if (reg_idx[2:0] == 3'(n)) rdata = {16'h0, ch[n]};
      end
    end
  end

endmodule

// File: tb/tb_wb_ppm_rx.sv
// Directed testbench for wb_ppm_rx, built with a 1 MHz clock so one clk equals
// one microsecond of PPM timing.
module tb_wb_ppm_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_stb_i = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_we_i  = 1'b0;
  logic [3:0]  wb_sel_i = 4'hF;
  logic        wb_ack_o;
  logic        ppm_in = 1'b0;
  logic        intr;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int last_rise   = 0;

`ifdef PPM_RX_FAILSAFE_EN
  localparam logic [31:0] FS_RD_RESET = 32'd1000;
  localparam logic [31:0] FS_RD_WR    = 32'd1234;
  localparam logic [31:0] CH0_LOST    = 32'd1000;
  localparam logic [31:0] CH7_LOST    = 32'd1000;
`else
  localparam logic [31:0] FS_RD_RESET = 32'd0;
  localparam logic [31:0] FS_RD_WR    = 32'd0;
  localparam logic [31:0] CH0_LOST    = 32'd800;
  localparam logic [31:0] CH7_LOST    = 32'd870;
`endif

  wb_ppm_rx #(
    .clk_freq     (1000000),
    .max_channels (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_stb_i (wb_stb_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_we_i  (wb_we_i),
    .wb_sel_i (wb_sel_i),
    .wb_ack_o (wb_ack_o),
    .ppm_in   (ppm_in),
    .intr     (intr)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)", tag, obs, obs, exp, exp);
    end
  endtask

  // One bus access, started and finished on a falling edge.
  task automatic wb_access(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                           output logic [31:0] rd);
    int k;
    wb_adr_i = adr;
    wb_we_i  = we;
    wb_dat_i = dat;
    wb_stb_i = 1'b1;
    wb_cyc_i = 1'b1;
    @(negedge clk);
    k = 0;
    while (!wb_ack_o && k < 4) begin
      @(negedge clk);
      k++;
    end
    check("wb_ack", {31'b0, wb_ack_o}, 32'd1);
    rd = wb_dat_o;
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    wb_we_i  = 1'b0;
    @(negedge clk);
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
    logic [31:0] rd;
    wb_access(adr, 1'b1, dat, rd);
  endtask

  task automatic wb_read(input logic [31:0] adr, input logic [31:0] exp, input string tag);
    logic [31:0] rd;
    wb_access(adr, 1'b0, 32'h0, rd);
    check(tag, rd, exp);
  endtask

  // Rising edge exactly `gap` cycles after the previous one, high for 100 cycles.
  // With w1c set, a STATUS frame_done clear lands on the same edge as the commit.
  task automatic ppm_rise(input int gap, input bit w1c);
    while (cyc < last_rise + gap) @(negedge clk);
    ppm_in    = 1'b1;
    last_rise = cyc;
    if (w1c) begin
      repeat (2) @(negedge clk);
      wb_write(32'h00, 32'h2);
      repeat (96) @(negedge clk);
    end else begin
      repeat (100) @(negedge clk);
    end
    ppm_in = 1'b0;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("ack_reset", {31'b0, wb_ack_o}, 32'd0);
    check("intr_reset", {31'b0, intr}, 32'd0);
    wb_read(32'h00, 32'h0, "status_reset");
    wb_read(32'h04, 32'h0, "ctrl_reset");
    wb_read(32'h08, FS_RD_RESET, "failsafe_reset");
    wb_read(32'h20, 32'h0, "ch0_reset");
    wb_read(32'h3C, 32'h0, "ch7_reset");
    wb_read(32'h0C, 32'h0, "unmapped_read");
    wb_write(32'h08, 32'd1234);
    wb_read(32'h08, FS_RD_WR, "failsafe_rw");
    wb_write(32'h08, 32'd1000);
    wb_write(32'h04, 32'h3);
    wb_read(32'h04, 32'h3, "ctrl_rw");
    last_rise = cyc;

    // Frame 1: sync, eight pulses 1000..1700, 5000 us sync.
    ppm_rise(3100, 1'b0);
    for (int i = 0; i < 8; i++) ppm_rise(1000 + 100 * i, 1'b0);
    ppm_rise(5000, 1'b0);
    check("intr_frame1", {31'b0, intr}, 32'd1);
    for (int n = 0; n < 8; n++) wb_read(32'h20 + 32'(4 * n), 32'(1000 + 100 * n), "ch_frame1");
    wb_read(32'h00, 32'h0001_0803, "status_frame1");
    wb_write(32'h20, 32'hDEAD);
    wb_read(32'h20, 32'd1000, "ch0_readonly");

    // Write-one-to-clear of frame_done drops the interrupt.
    wb_write(32'h00, 32'h2);
    wb_read(32'h00, 32'h0001_0801, "status_w1c");
    check("intr_w1c", {31'b0, intr}, 32'd0);

    // Frame 2: four pulses incl. 700/2300 limits, 3000 us sync, clear on commit edge.
    ppm_rise(2000, 1'b0);
    ppm_rise(1500, 1'b0);
    ppm_rise(700, 1'b0);
    ppm_rise(2300, 1'b0);
    ppm_rise(3000, 1'b1);
    wb_read(32'h00, 32'h0002_0403, "status_set_wins");
    check("intr_set_wins", {31'b0, intr}, 32'd1);
    wb_read(32'h20, 32'd2000, "ch0_frame2");
    wb_read(32'h24, 32'd1500, "ch1_frame2");
    wb_read(32'h28, 32'd700, "ch2_frame2");
    wb_read(32'h2C, 32'd2300, "ch3_frame2");
    wb_read(32'h30, 32'd1400, "ch4_stale_shadow");

    // Frame 3: a 400 us interval aborts the frame.
    ppm_rise(1000, 1'b0);
    ppm_rise(400, 1'b0);
    wb_read(32'h00, 32'h0002_0407, "status_error");
    wb_read(32'h20, 32'd2000, "ch0_after_error");
    wb_write(32'h00, 32'h6);
    wb_read(32'h00, 32'h0002_0401, "status_error_clear");

    // Back in IDLE: a pulse-length gap is ignored, then a sync restarts framing.
    ppm_rise(800, 1'b0);
    ppm_rise(3000, 1'b0);

    // Short frame of three pulses: error, no commit.
    for (int i = 0; i < 3; i++) ppm_rise(800, 1'b0);
    ppm_rise(3000, 1'b0);
    wb_read(32'h00, 32'h0002_0405, "status_short_frame");
    wb_read(32'h20, 32'd2000, "ch0_short_frame");
    wb_write(32'h00, 32'h4);

    // Ten pulses: the last two are dropped.
    for (int i = 0; i < 10; i++) ppm_rise(800 + 10 * i, 1'b0);
    ppm_rise(3000, 1'b0);
    wb_read(32'h00, 32'h0003_0803, "status_ten_pulses");
    wb_read(32'h20, 32'd800, "ch0_ten_pulses");
    wb_read(32'h3C, 32'd870, "ch7_ten_pulses");

    // Signal loss at 25000 us of silence.
    wait_until(last_rise + 24900);
    wb_read(32'h00, 32'h0003_0803, "status_before_timeout");
    wait_until(last_rise + 25100);
    wb_read(32'h00, 32'h0003_0802, "status_after_timeout");
    wb_read(32'h20, CH0_LOST, "ch0_after_loss");
    wb_read(32'h3C, CH7_LOST, "ch7_after_loss");

    // Reset in the middle of a frame.
    ppm_rise(25500, 1'b0);
    ppm_rise(1000, 1'b0);
    ppm_rise(1100, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("intr_mid_reset", {31'b0, intr}, 32'd0);
    wb_read(32'h00, 32'h0, "status_mid_reset");
    wb_read(32'h04, 32'h0, "ctrl_mid_reset");
    wb_read(32'h20, 32'h0, "ch0_mid_reset");
    wb_read(32'h3C, 32'h0, "ch7_mid_reset");
    wb_read(32'h08, FS_RD_RESET, "failsafe_mid_reset");

    // Decoding restarts from IDLE, interrupt left disabled.
    wb_write(32'h04, 32'h1);
    last_rise = cyc;
    ppm_rise(3100, 1'b0);
    ppm_rise(800, 1'b0);
    ppm_rise(900, 1'b0);
    ppm_rise(1000, 1'b0);
    ppm_rise(1100, 1'b0);
    ppm_rise(3000, 1'b0);
    wb_read(32'h00, 32'h0001_0403, "status_restart");
    wb_read(32'h2C, 32'd1100, "ch3_restart");
    check("intr_irq_disabled", {31'b0, intr}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
